// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sa_state_t;

endpackage

// File: rtl/halfadder.sv
// Single-bit half adder cell: s = a xor b, cout = a and b.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic cout
);

  assign s    = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first, one bit per clock, through two
// halfadder cells and a carry register; result held in a separate output register.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s1, c1, sum_bit, c2, carry_next;
  logic             load, last;

  halfadder u_ha_ab (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .s    (s1),
    .cout (c1)
  );

  halfadder u_ha_carry (
    .a    (s1),
    .b    (carry),
    .s    (sum_bit),
    .cout (c2)
  );

  assign carry_next = c1 | c2;
  // The new bit enters at the MSB; after WIDTH shifts this is the full sum.
  assign res_shift  = {sum_bit, res_sr};
  assign load       = start && (state == IDLE || state == DONE);
  assign last       = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_shift[WIDTH-1:1];
      carry  <= carry_next;
      cnt    <= cnt + CW'(1);
    end
  end

  // Output register changes only on entry to DONE, so sum/cout hold through SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last) begin
      sum  <= res_shift;
      cout <= carry_next;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
